display_set_controller: RTL and testbench

- Sequences the clock/calendar 7-segment display datapath between normal running and a user time-setting mode.
- Walks a set-mode FSM through the hour, minute, second, day, month and year fields on a mode button.
- Blinks the selected field by toggling that field's display enable.
- Issues one-cycle increment strobes to the field counters, and pauses time counting while setting.

---
 rtl/display_set_controller_if.sv | 36 +++
 rtl/display_set_controller.sv | 155 +++++++++++++++
 tb/tb_display_set_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/display_set_controller_if.sv
// Button inputs and display/counter control outputs of the clock/calendar
// set controller, bundled so the datapath side can be wired in one go.
interface display_set_controller_if;
  logic btn_mode;
  logic btn_inc;
  logic run_en;
  logic set_active;
  logic enable_s;
  logic enable_mi;
  logic enable_h;
  logic enable_d;
  logic enable_mo;
  logic enable_y;
  logic inc_s;
  logic inc_mi;
  logic inc_h;
  logic inc_d;
  logic inc_mo;
  logic inc_y;

  // Side that drives the buttons and consumes the controls.
  modport master (
    output btn_mode, btn_inc,
    input  run_en, set_active,
    input  enable_s, enable_mi, enable_h, enable_d, enable_mo, enable_y,
    input  inc_s, inc_mi, inc_h, inc_d, inc_mo, inc_y
  );

  // The controller itself.
  modport slave (
    input  btn_mode, btn_inc,
    output run_en, set_active,
    output enable_s, enable_mi, enable_h, enable_d, enable_mo, enable_y,
    output inc_s, inc_mi, inc_h, inc_d, inc_mo, inc_y
  );
endinterface

// File: rtl/display_set_controller.sv
// Clock/calendar display set controller: walks hour/min/sec/day/month/year
// set states on btn_mode, blinks the selected field, issues one-cycle
// increment strobes on btn_inc and pauses timekeeping while setting.
// Optional: define SETCTRL_TIMEOUT_EN to auto-return to RUN after
// TIMEOUT_HP blink half-periods without a button edge.
module display_set_controller #(
  parameter int BLINK_DIV  = 25000000,
  parameter int TIMEOUT_HP = 20
) (
  input logic                     clk,
  input logic                     rst,
  display_set_controller_if.slave bus
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_MI = 3'd2,
    SET_S  = 3'd3,
    SET_D  = 3'd4,
    SET_MO = 3'd5,
    SET_Y  = 3'd6
  } state_t;

  localparam int           CW         = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

  state_t        state_q, state_d;
  logic          btn_mode_q, btn_inc_q;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          run_en_q, run_en_d;
  logic          set_active_q, set_active_d;
  // Field index order: 0=H, 1=MI, 2=S, 3=D, 4=MO, 5=Y (enum value minus one).
  logic [5:0]    en_q, en_d;
  logic [5:0]    inc_q, inc_d;

  logic mode_edge, inc_edge, blink_wrap, timeout_hit;

  assign mode_edge  = bus.btn_mode & ~btn_mode_q;
  assign inc_edge   = bus.btn_inc & ~btn_inc_q;
  assign blink_wrap = (state_q != RUN) && (blink_cnt_q == BLINK_LAST);

`ifdef SETCTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_HP + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  assign timeout_hit = (to_cnt_q == TW'(TIMEOUT_HP));

  // Idle counter: half-period wraps since the last button edge in SET.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (mode_edge || inc_edge || state_d == RUN) begin
      to_cnt_d = '0;
    end else if (blink_wrap) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  logic [31:0] timeout_hp_unused;
  assign timeout_hp_unused = TIMEOUT_HP;
  assign timeout_hit       = 1'b0;
`endif

  // Next state: mode edges walk the fields; a button edge beats a timeout.
  always_comb begin
    state_d = state_q;
    if (mode_edge) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_MI;
        SET_MI:  state_d = SET_S;
        SET_S:   state_d = SET_D;
        SET_D:   state_d = SET_MO;
        SET_MO:  state_d = SET_Y;
        default: state_d = RUN;
      endcase
    end else if (!inc_edge && timeout_hit) begin
      state_d = RUN;
    end
  end

  // Blink timer: restarts visible on any state change or increment.
  always_comb begin
    blink_cnt_d  = '0;
    phase_d      = 1'b1;
    run_en_d     = (state_d == RUN);
    set_active_d = (state_d != RUN);
    if (state_d != state_q || inc_edge || state_q == RUN) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CW'(1);
      phase_d     = phase_q;
    end
  end

  // Per-field enable and strobe; a simultaneous mode edge swallows the inc.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_field
      assign en_d[gi]  = (state_d == state_t'(3'(gi + 1))) ? phase_d : 1'b1;
      assign inc_d[gi] = inc_edge && !mode_edge && (state_q == state_t'(3'(gi + 1)));
    end
  endgenerate

  // State, button history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      btn_mode_q   <= 1'b0;
      btn_inc_q    <= 1'b0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b1;
      run_en_q     <= 1'b1;
      set_active_q <= 1'b0;
      en_q         <= '1;
      inc_q        <= '0;
    end else begin
      state_q      <= state_d;
      btn_mode_q   <= bus.btn_mode;
      btn_inc_q    <= bus.btn_inc;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      run_en_q     <= run_en_d;
      set_active_q <= set_active_d;
      en_q         <= en_d;
      inc_q        <= inc_d;
    end
  end

  assign bus.run_en     = run_en_q;
  assign bus.set_active = set_active_q;
  assign bus.enable_h   = en_q[0];
  assign bus.enable_mi  = en_q[1];
  assign bus.enable_s   = en_q[2];
  assign bus.enable_d   = en_q[3];
  assign bus.enable_mo  = en_q[4];
  assign bus.enable_y   = en_q[5];
  assign bus.inc_h      = inc_q[0];
  assign bus.inc_mi     = inc_q[1];
  assign bus.inc_s      = inc_q[2];
  assign bus.inc_d      = inc_q[3];
  assign bus.inc_mo     = inc_q[4];
  assign bus.inc_y      = inc_q[5];

endmodule

// File: tb/tb_display_set_controller.sv
// Directed bench for display_set_controller with BLINK_DIV=4, TIMEOUT_HP=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_display_set_controller;
  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  display_set_controller_if bus ();

  display_set_controller #(
    .BLINK_DIV (4),
    .TIMEOUT_HP(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // {run_en, set_active, en h/mi/s/d/mo/y, inc h/mi/s/d/mo/y}
  function automatic logic [13:0] outs();
    return {bus.run_en, bus.set_active,
            bus.enable_h, bus.enable_mi, bus.enable_s,
            bus.enable_d, bus.enable_mo, bus.enable_y,
            bus.inc_h, bus.inc_mi, bus.inc_s,
            bus.inc_d, bus.inc_mo, bus.inc_y};
  endfunction

  // st: 0=RUN, 1=H, 2=MI, 3=S, 4=D, 5=MO, 6=Y; ph = blink phase of selected field.
  function automatic logic [13:0] expv(input int st, input logic ph, input logic [5:0] inc);
    logic [5:0] en;
    for (int f = 1; f <= 6; f++) en[6-f] = (st == f) ? ph : 1'b1;
    return {(st == 0), (st != 0), en, inc};
  endfunction

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle mode pulse; returns on the falling edge after it was sampled.
  task automatic press_mode();
    bus.btn_mode = 1'b1;
    tick();
    bus.btn_mode = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    tick();
    tick();
    check("reset", outs(), expv(0, 1'b1, 6'b0));
    rst = 1'b0;
    tick();
    check("reset_release", outs(), expv(0, 1'b1, 6'b0));

    // Full mode walk back to RUN.
    for (int i = 1; i <= 7; i++) begin
      press_mode();
      check($sformatf("walk%0d", i), outs(), expv(i % 7, 1'b1, 6'b0));
      tick();
    end

    // Blink in SET_MI: 4 on, 4 off, ...
    press_mode();
    check("enter_h", outs(), expv(1, 1'b1, 6'b0));
    tick();
    press_mode();
    for (int j = 0; j < 16; j++) begin
      check($sformatf("blink_mi%0d", j), outs(), expv(2, ((j / 4) % 2) == 0, 6'b0));
      tick();
    end

    // Into SET_D, let the field go dark, then hold btn_inc for 10 cycles.
    press_mode();
    check("enter_s", outs(), expv(3, 1'b1, 6'b0));
    tick();
    press_mode();
    for (int j = 0; j < 6; j++) begin
      check($sformatf("blink_d%0d", j), outs(), expv(4, j < 4, 6'b0));
      tick();
    end
    bus.btn_inc = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("inc_d%0d", k), outs(),
            expv(4, ((k / 4) % 2) == 0, (k == 0) ? 6'b000100 : 6'b000000));
    end
    bus.btn_inc = 1'b0;
    tick();

    // Back to RUN, then the same inc pulse must be ignored.
    for (int i = 0; i < 3; i++) begin
      press_mode();
      check($sformatf("to_run%0d", i), outs(), expv((5 + i) % 7, 1'b1, 6'b0));
      tick();
    end
    bus.btn_inc = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("inc_run%0d", k), outs(), expv(0, 1'b1, 6'b0));
    end
    bus.btn_inc = 1'b0;
    tick();

    // Simultaneous mode and inc edges in SET_H: mode wins, no strobe.
    press_mode();
    check("simul_enter_h", outs(), expv(1, 1'b1, 6'b0));
    tick();
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    tick();
    check("simul", outs(), expv(2, 1'b1, 6'b0));
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    tick();
    check("simul_after", outs(), expv(2, 1'b1, 6'b0));
    tick();

    // Idle in SET_S.
    press_mode();
    check("idle_enter_s", outs(), expv(3, 1'b1, 6'b0));
`ifdef SETCTRL_TIMEOUT_EN
    for (int j = 1; j <= 13; j++) begin
      tick();
      if (j == 12) check("timeout_pre", {12'b0, outs()[13:12]}, 14'b01);
      if (j == 13) check("timeout_run", outs(), expv(0, 1'b1, 6'b0));
    end
`else
    for (int j = 1; j <= 100; j++) begin
      tick();
      if (j == 13 || j == 100)
        check($sformatf("no_timeout%0d", j), {12'b0, outs()[13:12]}, 14'b01);
    end
    for (int i = 0; i < 4; i++) begin
      press_mode();
      tick();
    end
    check("idle_exit", outs(), expv(0, 1'b1, 6'b0));
`endif

    // Reset asserted mid-cycle while setting, with an inc edge pending.
    tick();
    press_mode();
    check("rst_enter_h", outs(), expv(1, 1'b1, 6'b0));
    tick();
    bus.btn_inc = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", outs(), expv(0, 1'b1, 6'b0));
    tick();
    check("rst_hold", outs(), expv(0, 1'b1, 6'b0));
    rst = 1'b0;
    tick();
    check("rst_release_inc", outs(), expv(0, 1'b1, 6'b0));
    bus.btn_inc = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
